game_round_sequencer: RTL

//  Sequences one game round: arms on start button, 3 s ready countdown, 30 s play window, then holds result.

---
 rtl/game_round_if.sv | 21 ++
 rtl/game_round_sequencer.sv | 87 ++++++++
 2 files changed

// File: rtl/game_round_if.sv
// game_round_if: start/hit/miss inputs and round status outputs of game_round_sequencer.
interface game_round_if;
    logic       start;
    logic       hit;
    logic       miss;
    logic [1:0] state;
    logic       game_en;
    logic       music_en;
    logic [5:0] time_left;
    logic [7:0] score;
    logic       round_done;
    logic [7:0] high_score;
    modport master (
        output start, hit, miss,
        input  state, game_en, music_en, time_left, score, round_done, high_score
    );
    modport slave (
        input  start, hit, miss,
        output state, game_en, music_en, time_left, score, round_done, high_score
    );
endinterface

// File: rtl/game_round_sequencer.sv
// game_round_sequencer: idle/ready/play/over round sequencer with a seconds countdown and saturating score.
// Define HIGH_SCORE_EN to keep the best completed-round score since reset; otherwise high_score reads 0.
module game_round_sequencer #(
    parameter int CLK_HZ    = 100_000_000,
    parameter int READY_SEC = 3,
    parameter int ROUND_SEC = 30,
    parameter int MAX_SCORE = 99
) (
    input logic         clk,
    input logic         rst_n,
    game_round_if.slave bus
);
    localparam int CW = $clog2(CLK_HZ + 1);
    localparam logic [CW-1:0] TERM = CW'(CLK_HZ - 1);
    typedef enum logic [1:0] {IDLE, READY, PLAY, OVER} state_t;
    state_t        state_q, state_n;
    logic [CW-1:0] cnt_q;
    logic [5:0]    time_q, time_n;
    logic [7:0]    score_q, score_n;
    logic          done_q, done_n;
    logic          game_q, music_q;
    logic [2:0]    sync_q;
    logic          start_evt, tick, up, dn, last;
    assign start_evt = sync_q[1] & ~sync_q[2];
    assign tick      = cnt_q == TERM;
    assign up        = bus.hit & ~bus.miss;
    assign dn        = bus.miss & ~bus.hit;
    assign last      = tick && time_q == 6'd1;
    // two synchronizer stages plus the previous synchronized level for edge detection
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) sync_q <= '0;
        else sync_q <= {sync_q[1:0], bus.start};
    always_comb begin
        state_n = state_q;
        time_n  = time_q;
        score_n = score_q;
        done_n  = 1'b0;
        if (start_evt && state_q != READY) begin
            state_n = READY;
            time_n  = 6'(READY_SEC);
            score_n = '0;
        end else if (state_q == READY && tick) begin
            state_n = last ? PLAY : READY;
            time_n  = last ? 6'(ROUND_SEC) : time_q - 6'd1;
        end else if (state_q == PLAY) begin
            score_n = (up && score_q != 8'(MAX_SCORE)) ? score_q + 8'd1 :
                      (dn && score_q != 8'd0)          ? score_q - 8'd1 : score_q;
            state_n = last ? OVER : PLAY;
            time_n  = (tick && time_q != 6'd0) ? time_q - 6'd1 : time_q;
            done_n  = last;
        end
    end
    // the prescaler restarts on every state change so each phase begins with a full second
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            time_q  <= '0;
            score_q <= '0;
            done_q  <= 1'b0;
            game_q  <= 1'b0;
            music_q <= 1'b0;
        end else begin
            state_q <= state_n;
            cnt_q   <= (state_n != state_q || !(state_q inside {READY, PLAY}) || tick) ? '0 : cnt_q + CW'(1);
            time_q  <= time_n;
            score_q <= score_n;
            done_q  <= done_n;
            game_q  <= state_n == PLAY;
            music_q <= state_n inside {READY, PLAY};
        end
    assign bus.state      = state_q;
    assign bus.game_en    = game_q;
    assign bus.music_en   = music_q;
    assign bus.time_left  = time_q;
    assign bus.score      = score_q;
    assign bus.round_done = done_q;
`ifdef HIGH_SCORE_EN
    logic [7:0] high_q;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) high_q <= '0;
        else if (done_n && score_n > high_q) high_q <= score_n;
    assign bus.high_score = high_q;
`else
    assign bus.high_score = 8'd0;
`endif
endmodule
